// File: rtl/fofb_setpoint_framer.sv
// FOFB setpoint framer: ping-pong capture of setpoint bursts, framed re-emit.
// Optional checksum trailer enabled by defining FRAMER_CHECKSUM_EN.
module fofb_setpoint_framer #(
  parameter int          RESULT_COUNT = 1,
  parameter logic [15:0] FRAME_MAGIC  = 16'hF0FB
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clearStrobe,
  input  logic        SETPOINT_TVALID,
  input  logic        SETPOINT_TLAST,
  input  logic [31:0] SETPOINT_TDATA,
  output logic        PS_TVALID,
  input  logic        PS_TREADY,
  output logic        PS_TLAST,
  output logic [31:0] PS_TDATA,
  output logic [31:0] status
);

  localparam int IW =
    (RESULT_COUNT > 1) ? $clog2(RESULT_COUNT) : 1;
  localparam logic [IW-1:0] LAST_IDX =
    IW'(RESULT_COUNT - 1);

  typedef enum logic [1:0] {
    B_FREE, B_FILLING, B_READY
  } bank_e;

  typedef enum logic [1:0] {
    CAP_IDLE, CAP_FILL, CAP_DISCARD
  } cap_e;

  typedef enum logic [1:0] {
    TX_IDLE, TX_HEADER, TX_DATA, TX_TRAILER
  } tx_e;

  logic [31:0]   r_mem [2][RESULT_COUNT];
  bank_e         r_bank [2];
  logic          r_wp;
  logic          r_rp;
  logic          w_rp_n;

  cap_e          r_cap;
  cap_e          w_cap_nxt;
  logic [IW-1:0] r_widx;
  logic [IW-1:0] w_widx_nxt;
  logic [IW-1:0] w_waddr;
  logic          r_ovr;
  logic          w_ovr_nxt;
  logic          w_free;
  logic          w_wr;
  logic          w_commit;
  logic          w_start;
  logic          w_abort;
  logic          w_short_inc;
  logic          w_long_inc;
  logic          w_ovr_inc;

  tx_e           r_tx;
  tx_e           w_tx_nxt;
  logic [IW-1:0] r_ridx;
  logic [IW-1:0] w_ridx_nxt;
  logic [IW-1:0] w_ridx_inc;
  logic          w_fire;
  logic          w_done;
  logic          w_load;
  logic          w_hdr_ld;
  logic [31:0]   w_word;
  logic          w_word_last;

  logic          r_valid;
  logic          r_last;
  logic [31:0]   r_data;
  logic [7:0]    r_seq;
  logic [7:0]    r_short_cnt;
  logic [7:0]    r_long_cnt;
  logic [7:0]    r_ovr_cnt;

`ifdef FRAMER_CHECKSUM_EN
  logic [31:0]   r_sum;
`endif

  function automatic logic [31:0] hdr(
    input logic [7:0] s
  );
    return {FRAME_MAGIC, s, 8'(RESULT_COUNT)};
  endfunction

  function automatic logic [7:0] bump(
    input logic [7:0] c,
    input logic       inc,
    input logic       clr
  );
    if (clr)
      return 8'd0;
    else if (inc && c != 8'hFF)
      return c + 8'd1;
    else
      return c;
  endfunction

  assign w_fire     = r_valid && PS_TREADY;
  assign w_rp_n     = ~r_rp;
  assign w_ridx_inc = r_ridx + IW'(1);

  // a bank released this cycle by transmit may be claimed immediately
  assign w_free = (r_bank[r_wp] == B_FREE) ||
                  (w_done && (r_rp == r_wp));

  assign w_waddr = (r_cap == CAP_IDLE) ? '0 : r_widx;

  always_comb begin
    w_cap_nxt   = r_cap;
    w_widx_nxt  = r_widx;
    w_ovr_nxt   = r_ovr;
    w_wr        = 1'b0;
    w_commit    = 1'b0;
    w_start     = 1'b0;
    w_abort     = 1'b0;
    w_short_inc = 1'b0;
    w_long_inc  = 1'b0;
    w_ovr_inc   = 1'b0;
    if (SETPOINT_TVALID) begin
      unique case (r_cap)
        CAP_IDLE: begin
          if (!w_free) begin
            if (SETPOINT_TLAST) begin
              w_ovr_inc = 1'b1;
            end else begin
              w_cap_nxt = CAP_DISCARD;
              w_ovr_nxt = 1'b1;
            end
          end else begin
            w_wr = 1'b1;
            if (LAST_IDX == '0) begin
              if (SETPOINT_TLAST) begin
                w_commit = 1'b1;
              end else begin
                w_long_inc = 1'b1;
                w_abort    = 1'b1;
                w_cap_nxt  = CAP_DISCARD;
                w_ovr_nxt  = 1'b0;
              end
            end else if (SETPOINT_TLAST) begin
              w_short_inc = 1'b1;
            end else begin
              w_start    = 1'b1;
              w_widx_nxt = IW'(1);
              w_cap_nxt  = CAP_FILL;
            end
          end
        end
        CAP_FILL: begin
          w_wr = 1'b1;
          if (r_widx == LAST_IDX) begin
            if (SETPOINT_TLAST) begin
              w_commit  = 1'b1;
              w_cap_nxt = CAP_IDLE;
            end else begin
              w_long_inc = 1'b1;
              w_abort    = 1'b1;
              w_cap_nxt  = CAP_DISCARD;
              w_ovr_nxt  = 1'b0;
            end
          end else if (SETPOINT_TLAST) begin
            w_short_inc = 1'b1;
            w_abort     = 1'b1;
            w_cap_nxt   = CAP_IDLE;
          end else begin
            w_widx_nxt = r_widx + IW'(1);
          end
        end
        CAP_DISCARD: begin
          if (SETPOINT_TLAST) begin
            w_ovr_inc = r_ovr;
            w_ovr_nxt = 1'b0;
            w_cap_nxt = CAP_IDLE;
          end
        end
        default: w_cap_nxt = CAP_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cap  <= CAP_IDLE;
      r_widx <= '0;
      r_ovr  <= 1'b0;
    end else begin
      r_cap  <= w_cap_nxt;
      r_widx <= w_widx_nxt;
      r_ovr  <= w_ovr_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (w_wr)
      r_mem[r_wp][w_waddr] <= SETPOINT_TDATA;
  end

  // capture updates come last so a same-cycle reclaim wins over release
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_bank[0] <= B_FREE;
      r_bank[1] <= B_FREE;
      r_wp      <= 1'b0;
      r_rp      <= 1'b0;
    end else begin
      if (w_done) begin
        r_bank[r_rp] <= B_FREE;
        r_rp         <= w_rp_n;
      end
      if (w_start)
        r_bank[r_wp] <= B_FILLING;
      if (w_abort)
        r_bank[r_wp] <= B_FREE;
      if (w_commit) begin
        r_bank[r_wp] <= B_READY;
        r_wp         <= ~r_wp;
      end
    end
  end

  // state names the word currently held in the output register
  always_comb begin
    w_tx_nxt    = r_tx;
    w_ridx_nxt  = r_ridx;
    w_load      = 1'b0;
    w_hdr_ld    = 1'b0;
    w_word      = r_data;
    w_word_last = 1'b0;
    w_done      = 1'b0;
    unique case (r_tx)
      TX_IDLE: begin
        if (r_bank[r_rp] == B_READY) begin
          w_load   = 1'b1;
          w_hdr_ld = 1'b1;
          w_word   = hdr(r_seq);
          w_tx_nxt = TX_HEADER;
        end
      end
      TX_HEADER: begin
        if (w_fire) begin
          w_load     = 1'b1;
          w_word     = r_mem[r_rp][0];
`ifdef FRAMER_CHECKSUM_EN
          w_word_last = 1'b0;
`else
          w_word_last = (LAST_IDX == '0);
`endif
          w_ridx_nxt = '0;
          w_tx_nxt   = TX_DATA;
        end
      end
      TX_DATA: begin
        if (w_fire) begin
          if (r_ridx != LAST_IDX) begin
            w_load     = 1'b1;
            w_word     = r_mem[r_rp][w_ridx_inc];
`ifdef FRAMER_CHECKSUM_EN
            w_word_last = 1'b0;
`else
            w_word_last = (w_ridx_inc == LAST_IDX);
`endif
            w_ridx_nxt = w_ridx_inc;
          end else begin
`ifdef FRAMER_CHECKSUM_EN
            w_load      = 1'b1;
            w_word      = -r_sum;
            w_word_last = 1'b1;
            w_tx_nxt    = TX_TRAILER;
`else
            w_done = 1'b1;
`endif
          end
        end
      end
      TX_TRAILER: begin
        if (w_fire)
          w_done = 1'b1;
      end
      default: w_tx_nxt = TX_IDLE;
    endcase
    if (w_done) begin
      w_tx_nxt = TX_IDLE;
      if (r_bank[w_rp_n] == B_READY) begin
        w_load   = 1'b1;
        w_hdr_ld = 1'b1;
        w_word   = hdr(r_seq + 8'd1);
        w_tx_nxt = TX_HEADER;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_tx    <= TX_IDLE;
      r_ridx  <= '0;
      r_valid <= 1'b0;
      r_last  <= 1'b0;
      r_data  <= '0;
      r_seq   <= '0;
    end else begin
      r_tx   <= w_tx_nxt;
      r_ridx <= w_ridx_nxt;
      if (w_load) begin
        r_valid <= 1'b1;
        r_data  <= w_word;
        r_last  <= w_word_last;
      end else if (w_fire) begin
        r_valid <= 1'b0;
        r_last  <= 1'b0;
      end
      if (w_done)
        r_seq <= r_seq + 8'd1;
    end
  end

`ifdef FRAMER_CHECKSUM_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      r_sum <= '0;
    else if (w_load)
      r_sum <= w_hdr_ld ? w_word : r_sum + w_word;
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_short_cnt <= '0;
      r_long_cnt  <= '0;
      r_ovr_cnt   <= '0;
    end else begin
      r_short_cnt <= bump(r_short_cnt, w_short_inc,
                          clearStrobe);
      r_long_cnt  <= bump(r_long_cnt, w_long_inc,
                          clearStrobe);
      r_ovr_cnt   <= bump(r_ovr_cnt, w_ovr_inc,
                          clearStrobe);
    end
  end

  assign PS_TVALID = r_valid;
  assign PS_TLAST  = r_last;
  assign PS_TDATA  = r_data;
  assign status    = {r_ovr_cnt, r_short_cnt,
                      r_long_cnt, r_seq};

endmodule

// File: tb/tb_fofb_setpoint_framer.sv
// Bench for fofb_setpoint_framer: frame-level model plus directed scenarios.
// Works with or without FRAMER_CHECKSUM_EN defined.
module tb_fofb_setpoint_framer;

  localparam int RC = 4;
`ifdef FRAMER_CHECKSUM_EN
  localparam bit CK = 1'b1;
`else
  localparam bit CK = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        clearStrobe = 1'b0;
  logic        sv = 1'b0;
  logic        sl = 1'b0;
  logic [31:0] sd = '0;
  logic        ps_v;
  logic        ps_r = 1'b1;
  logic        ps_l;
  logic [31:0] ps_d;
  logic [31:0] status;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  fofb_setpoint_framer #(
    .RESULT_COUNT(RC),
    .FRAME_MAGIC(16'hF0FB)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .clearStrobe(clearStrobe),
    .SETPOINT_TVALID(sv),
    .SETPOINT_TLAST(sl),
    .SETPOINT_TDATA(sd),
    .PS_TVALID(ps_v),
    .PS_TREADY(ps_r),
    .PS_TLAST(ps_l),
    .PS_TDATA(ps_d),
    .status(status)
  );

  task automatic check(input string name,
                       input logic [31:0] act,
                       input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %08h expected %08h",
               name, act, exp);
    end
  endtask

  // ---------------- frame-level model ----------------
  logic [32:0] exp_q[$];
  logic [31:0] buf_q[$];
  int          m_mode;
  int          m_pend;
  int          m_commits;
  logic        m_isovr;
  logic [7:0]  m_seq, m_short, m_long, m_ovr;
  logic        hold_v, hold_l;
  logic [31:0] hold_d;

  function automatic logic [7:0] sat(input logic [7:0] c,
                                     input logic inc,
                                     input logic clr);
    if (clr) return 8'd0;
    if (inc && c != 8'hFF) return c + 8'd1;
    return c;
  endfunction

  task automatic model_reset();
    exp_q.delete();
    buf_q.delete();
    m_mode = 0; m_pend = 0; m_commits = 0;
    m_isovr = 1'b0;
    m_seq = 0; m_short = 0; m_long = 0; m_ovr = 0;
    hold_v = 1'b0; hold_l = 1'b0; hold_d = '0;
  endtask

  task automatic commit_frame();
    logic [31:0] sum;
    sum = {16'hF0FB, 8'(m_commits), 8'(RC)};
    exp_q.push_back({1'b0, sum});
    for (int i = 0; i < RC; i++) begin
      sum += buf_q[i];
      exp_q.push_back({(!CK && i == RC-1), buf_q[i]});
    end
    if (CK) exp_q.push_back({1'b1, -sum});
    m_commits++;
    m_pend++;
  endtask

  always @(negedge clk) begin
    logic si, li, oi;
    logic [32:0] w;
    if (!rst_n) begin
      model_reset();
    end else begin
      check("status", status,
            {m_ovr, m_short, m_long, m_seq});
      if (hold_v) begin
        check("hold_valid", 32'(ps_v), 32'd1);
        check("hold_data", ps_d, hold_d);
        check("hold_last", 32'(ps_l), 32'(hold_l));
      end
      if (ps_v) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_errors++;
          $display("FAIL spurious_word: got %08h expected no word",
                   ps_d);
        end else begin
          w = exp_q[0];
          check("word_data", ps_d, w[31:0]);
          check("word_last", 32'(ps_l), 32'(w[32]));
          if (ps_r) begin
            w = exp_q.pop_front();
            if (w[32]) begin
              m_pend--;
              m_seq++;
            end
          end
        end
      end
      hold_v = ps_v && !ps_r;
      hold_d = ps_d;
      hold_l = ps_l;
      si = 1'b0; li = 1'b0; oi = 1'b0;
      if (sv) begin
        case (m_mode)
          0: begin
            if (m_pend >= 2) begin
              if (sl) oi = 1'b1;
              else begin m_mode = 2; m_isovr = 1'b1; end
            end else begin
              buf_q.delete();
              buf_q.push_back(sd);
              if (RC == 1 && sl) commit_frame();
              else if (sl) si = 1'b1;
              else if (RC == 1) begin
                li = 1'b1; m_mode = 2; m_isovr = 1'b0;
              end else m_mode = 1;
            end
          end
          1: begin
            buf_q.push_back(sd);
            if (buf_q.size() == RC) begin
              if (sl) begin commit_frame(); m_mode = 0; end
              else begin li = 1'b1; m_mode = 2; m_isovr = 1'b0; end
            end else if (sl) begin
              si = 1'b1; m_mode = 0;
            end
          end
          default: begin
            if (sl) begin
              oi = m_isovr; m_isovr = 1'b0; m_mode = 0;
            end
          end
        endcase
      end
      m_short = sat(m_short, si, clearStrobe);
      m_long  = sat(m_long, li, clearStrobe);
      m_ovr   = sat(m_ovr, oi, clearStrobe);
    end
  end

  // ---------------- stimulus ----------------
  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic beat(input logic [31:0] d, input logic l);
    sv = 1'b1; sd = d; sl = l;
    step();
    sv = 1'b0; sl = 1'b0;
  endtask

  task automatic burst(input logic [31:0] base,
                       input int n, input int last_at);
    for (int i = 1; i <= n; i++)
      beat(base + 32'(i - 1), i == last_at);
  endtask

  task automatic drain(input string name, input int budget);
    bit done;
    done = 1'b0;
    for (int i = 0; i < budget && !done; i++) begin
      step();
      if (exp_q.size() == 0 && !ps_v) done = 1'b1;
    end
    n_checks++;
    if (!done) begin
      n_errors++;
      $display("FAIL %s: got %0d words pending expected 0",
               name, exp_q.size());
    end
  endtask

  initial begin
    bit found;
    rst_n = 1'b0;
    ps_r  = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_valid", 32'(ps_v), 32'd0);
    check("rst_last", 32'(ps_l), 32'd0);
    check("rst_data", ps_d, 32'd0);
    check("rst_status", status, 32'd0);
    rst_n = 1'b1;
    step();

    // nominal frame
    burst(32'd1, 4, 4);
    check("hdr_not_yet", 32'(ps_v), 32'd0);
    step();
    check("hdr_valid", 32'(ps_v), 32'd1);
    check("hdr_word", ps_d, 32'hF0FB0004);
    for (int k = 1; k <= 4; k++) begin
      step();
      check("nom_data", ps_d, 32'(k));
      check("nom_last", 32'(ps_l), 32'(!CK && k == 4));
    end
`ifdef FRAMER_CHECKSUM_EN
    step();
    check("trailer", ps_d, 32'h0F04FFF2);
    check("trailer_last", 32'(ps_l), 32'd1);
`endif
    step();
    check("nom_seq", status, 32'h00000001);

    // backpressure
    burst(32'd1, 4, 4);
    for (int k = 0; k < 16; k++) begin
      ps_r = (k % 2) == 0;
      step();
    end
    ps_r = 1'b1;
    drain("bp_drain", 20);
    check("bp_seq", status, 32'h00000002);

    // short then long, then a good one
    burst(32'd10, 3, 3);
    burst(32'd20, 6, 6);
    repeat (3) step();
    check("short_long", status, 32'h00010102);
    burst(32'd30, 4, 4);
    drain("good_after_bad", 20);
    check("good_seq", status, 32'h00010103);

    // overrun from a clean reset
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    check("rst2_status", status, 32'd0);
    ps_r = 1'b0;
    burst(32'd40, 4, 4);
    burst(32'd50, 4, 4);
    burst(32'd60, 4, 4);
    check("ovr_status", status, 32'h01000000);
    check("ovr_held_valid", 32'(ps_v), 32'd1);
    check("ovr_held_hdr", ps_d, 32'hF0FB0004);
    ps_r = 1'b1;
    drain("ovr_drain", 30);
    check("ovr_seq", status, 32'h01000002);

    // saturation and clear
    for (int k = 0; k < 300; k++) burst(32'(k), 1, 1);
    check("short_sat", status, 32'h01FF0002);
    clearStrobe = 1'b1;
    beat(32'd7, 1'b1);
    clearStrobe = 1'b0;
    check("clear", status, 32'h00000002);

    // reset in the middle of a frame
    burst(32'd9, 4, 4);
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      step();
      if (ps_v && ps_d == 32'd10) found = 1'b1;
    end
    n_checks++;
    if (!found) begin
      n_errors++;
      $display("FAIL wait_word2: got timeout expected data 0000000a");
    end
    #2 rst_n = 1'b0;
    #1;
    check("async_valid", 32'(ps_v), 32'd0);
    check("async_data", ps_d, 32'd0);
    check("async_status", status, 32'd0);
    @(posedge clk);
    @(posedge clk);
    #1 rst_n = 1'b1;
    step();
    burst(32'd5, 4, 4);
    drain("post_reset_drain", 20);
    check("post_reset_seq", status, 32'h00000001);

    repeat (2) step();
    $display("Simulation finished: %0d checks, %0d errors",
             n_checks, n_errors);
    $finish;
  end

endmodule
